apuracao_reader: RTL and testbench

Tally reader for the electronic ballot box. When counting closes, it snapshots the cascaded BCD vote counters of every candidate and streams them out digit by digit over a valid/ready interface. It also computes the winning candidate, excluding the null-vote tally. It sits between the per-candidate `contadorBCD` chains and the result display/serial path, on the read side of those counters.

---
 rtl/urna_pkg.sv | 24 ++
 rtl/bcd_compare.sv | 33 +++
 rtl/apuracao_reader.sv | 168 ++++++++++++++++
 tb/tb_apuracao_reader.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/urna_pkg.sv
// Shared definitions for the ballot-box tally path: candidate indices,
// BCD digit width and the reader's state encoding.
package urna_pkg;

    localparam int ARTHUR  = 0;
    localparam int LEANDRO = 1;
    localparam int MATEUS  = 2;
    localparam int PABLO   = 3;
    localparam int NULO    = 4;

    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        SEND,
        DONE
    } state_e;

    function automatic logic bcd_invalid(input logic [BCD_W-1:0] digit);
        return digit > 4'd9;
    endfunction

endpackage

// File: rtl/bcd_compare.sv
// Combinational magnitude comparator for two multi-digit BCD words,
// resolved from the most significant digit down.
module bcd_compare
    import urna_pkg::*;
#(
    parameter int NUM_DIGITS = 6
) (
    input  logic [NUM_DIGITS-1:0][BCD_W-1:0] a,
    input  logic [NUM_DIGITS-1:0][BCD_W-1:0] b,
    output logic                             gt,
    output logic                             eq
);

    // NOTE: every output of a combinational block gets a default before any
    // branch, so no path through the block can leave it unassigned (latch).
    always_comb begin
        gt = 1'b0;
        eq = 1'b1;
        // The first differing digit from the top decides; raw nibble order
        // keeps the result defined even for non-BCD digits.
        for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
            if (eq) begin
                if (a[d] > b[d]) begin
                    gt = 1'b1;
                    eq = 1'b0;
                end else if (a[d] < b[d]) begin
                    eq = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/apuracao_reader.sv
// Snapshots all candidate BCD tallies on start, picks the winner among the
// non-null candidates, then streams every digit over a valid/ready port.
module apuracao_reader
    import urna_pkg::*;
#(
    parameter  int NUM_CAND   = 5,
    parameter  int NUM_DIGITS = 6,
    localparam int CW         = $clog2(NUM_CAND),
    localparam int PW         = $clog2(NUM_DIGITS)
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                start,
    input  logic [NUM_CAND*NUM_DIGITS*BCD_W-1:0] tally,
    output logic [BCD_W-1:0]                    out_digit,
    output logic [CW-1:0]                       out_cand,
    output logic [PW-1:0]                       out_pos,
    output logic                                out_last,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic                                busy,
    output logic                                done,
    output logic [CW-1:0]                       winner,
    output logic                                tie,
    output logic                                bcd_err
);

    typedef logic [NUM_DIGITS-1:0][BCD_W-1:0] word_t;

    localparam logic [CW-1:0] CAND_NULL = CW'(NUM_CAND - 1);
    localparam logic [PW-1:0] POS_TOP   = PW'(NUM_DIGITS - 1);

    state_e                     state_q, state_d;
    word_t [NUM_CAND-1:0]       snap_q, snap_d;
    logic  [CW-1:0]             cand_q, cand_d;
    logic  [PW-1:0]             pos_q, pos_d;
    logic  [CW-1:0]             best_q, best_d;
    logic                       tie_q, tie_d;
    logic                       err_q, err_d;

    logic                       cmp_gt;
    logic                       cmp_eq;
    logic  [BCD_W-1:0]          cur_digit;
    logic                       last_beat;
    logic                       sending;

    // cand_q doubles as the COMPARE scan index and the SEND candidate counter.
    bcd_compare #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bcd_compare (
        .a  (snap_q[cand_q]),
        .b  (snap_q[best_q]),
        .gt (cmp_gt),
        .eq (cmp_eq)
    );

    assign sending   = (state_q == SEND);
    assign cur_digit = snap_q[cand_q][pos_q];
    assign last_beat = (cand_q == CAND_NULL) && (pos_q == '0);

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        cand_d  = cand_q;
        pos_d   = pos_q;
        best_d  = best_q;
        tie_d   = tie_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    snap_d  = tally;
                    cand_d  = '0;
                    pos_d   = POS_TOP;
                    best_d  = '0;
                    tie_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = COMPARE;
                end
            end

            COMPARE: begin
                // The null index is walked but never scored, which lands the
                // first beat exactly NUM_CAND edges after start.
                if (cand_q != CAND_NULL) begin
                    if (cand_q == '0) begin
                        best_d = '0;
                        tie_d  = 1'b0;
                    end else if (cmp_gt) begin
                        best_d = cand_q;
                        tie_d  = 1'b0;
                    end else if (cmp_eq) begin
                        tie_d  = 1'b1;
                    end
                    cand_d = cand_q + CW'(1);
                end else begin
                    cand_d  = '0;
                    pos_d   = POS_TOP;
                    state_d = SEND;
                end
            end

            SEND: begin
                if (out_ready) begin
                    if (bcd_invalid(cur_digit)) begin
                        err_d = 1'b1;
                    end
                    if (last_beat) begin
                        state_d = DONE;
                    end else if (pos_q == '0) begin
                        pos_d  = POS_TOP;
                        cand_d = cand_q + CW'(1);
                    end else begin
                        pos_d  = pos_q - PW'(1);
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            // NOTE: the snapshot array is deliberately reset; the reset state
            // of the reader is all-zero, including captured tallies.
            snap_q  <= '0;
            cand_q  <= '0;
            pos_q   <= '0;
            best_q  <= '0;
            tie_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            cand_q  <= cand_d;
            pos_q   <= pos_d;
            best_q  <= best_d;
            tie_q   <= tie_d;
            err_q   <= err_d;
        end
    end

    // Payload is gated by SEND so idle and reset outputs read as zero; it
    // depends only on registers, never on out_ready.
    assign out_valid = sending;
    assign out_digit = sending ? cur_digit : '0;
    assign out_cand  = sending ? cand_q : '0;
    assign out_pos   = sending ? pos_q : '0;
    assign out_last  = sending & last_beat;

    assign busy    = (state_q == COMPARE) || (state_q == SEND);
    assign done    = (state_q == DONE);
    assign winner  = best_q;
    assign tie     = tie_q;
    assign bcd_err = err_q;

endmodule

// File: tb/tb_apuracao_reader.sv
// Randomized scoreboard bench for apuracao_reader: a stimulus thread queues
// expected beats/results from a tally-level model; a monitor pops and compares.
module tb_apuracao_reader;
    import urna_pkg::*;

    localparam int NC = 5;
    localparam int ND = 6;
    localparam int TW = NC * ND * 4;
    localparam int CW = $clog2(NC);
    localparam int PW = $clog2(ND);

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [TW-1:0] tally;
    logic          out_ready;
    logic [3:0]    out_digit;
    logic [CW-1:0] out_cand;
    logic [PW-1:0] out_pos;
    logic          out_last;
    logic          out_valid;
    logic          busy;
    logic          done;
    logic [CW-1:0] winner;
    logic          tie;
    logic          bcd_err;

    apuracao_reader #(
        .NUM_CAND   (NC),
        .NUM_DIGITS (ND)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .tally     (tally),
        .out_digit (out_digit),
        .out_cand  (out_cand),
        .out_pos   (out_pos),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .winner    (winner),
        .tie       (tie),
        .bcd_err   (bcd_err)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0]    digit;
        logic [CW-1:0] cand;
        logic [PW-1:0] pos;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic [CW-1:0] winner;
        logic          tie;
        logic          err;
    } result_t;

    beat_t   beat_q[$];
    result_t res_q[$];

    int n_cmp      = 0;
    int n_bad      = 0;
    int cyc        = 0;
    int xfer_cnt   = 0;
    int done_cnt   = 0;
    int rdy_mode   = 0;
    int start_edge = 0;

    logic [18:0] all_outs;
    assign all_outs = {out_digit, out_cand, out_pos, out_last, out_valid,
                       busy, done, winner, tie, bcd_err};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [TW-1:0] pack_dec(input int unsigned a, input int unsigned l,
                                               input int unsigned m, input int unsigned p,
                                               input int unsigned n);
        int unsigned v[NC];
        logic [TW-1:0] t;
        v[0] = a; v[1] = l; v[2] = m; v[3] = p; v[4] = n;
        t = '0;
        for (int c = 0; c < NC; c++) begin
            int unsigned x = v[c];
            for (int d = 0; d < ND; d++) begin
                t[(c*ND+d)*4 +: 4] = 4'(x % 10);
                x = x / 10;
            end
        end
        return t;
    endfunction

    // Reference model: a tally word read as a plain hex integer orders exactly
    // like a digit-wise comparison from the top digit.
    task automatic push_expect(input logic [TW-1:0] t);
        logic [ND*4-1:0] vals[NC];
        logic [ND*4-1:0] top;
        result_t r;
        beat_t   b;
        int      hits;
        for (int c = 0; c < NC; c++) vals[c] = t[c*ND*4 +: ND*4];
        top = 0;
        for (int c = 0; c < NC - 1; c++) if (vals[c] > top) top = vals[c];
        r.winner = '0;
        hits     = 0;
        for (int c = NC - 2; c >= 0; c--) begin
            if (vals[c] == top) begin
                r.winner = CW'(c);
                hits++;
            end
        end
        r.tie = (hits > 1);
        r.err = 1'b0;
        for (int i = 0; i < NC * ND; i++) if (t[i*4 +: 4] > 4'd9) r.err = 1'b1;
        res_q.push_back(r);
        for (int c = 0; c < NC; c++) begin
            for (int p = ND - 1; p >= 0; p--) begin
                b.digit = t[(c*ND+p)*4 +: 4];
                b.cand  = CW'(c);
                b.pos   = PW'(p);
                b.last  = (c == NC - 1) && (p == 0);
                beat_q.push_back(b);
            end
        end
    endtask

    task automatic issue_start(input logic [TW-1:0] t);
        @(posedge clock);
        #1;
        tally = t;
        start = 1'b1;
        push_expect(t);
        start_edge = cyc + 1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int first_rel, output int done_rel);
        first_rel = -1;
        done_rel  = -1;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clock);
            if (out_valid && first_rel < 0) first_rel = cyc - start_edge;
            if (done) begin
                done_rel = cyc - start_edge;
                break;
            end
        end
        check("done_reached", 64'(done_rel >= 0), 64'd1);
        check("beats_drained_at_done", 64'(beat_q.size()), 64'd0);
    endtask

    function automatic logic [TW-1:0] rand_tally();
        logic [TW-1:0] t;
        int unsigned   hi;
        hi = ($urandom_range(0, 1) == 1) ? 3 : 999999;
        t = pack_dec($urandom_range(0, hi), $urandom_range(0, hi), $urandom_range(0, hi),
                     $urandom_range(0, hi), $urandom_range(0, 999999));
        if ($urandom_range(0, 3) == 0) begin
            int idx = $urandom_range(0, NC * ND - 1);
            t[idx*4 +: 4] = 4'($urandom_range(10, 15));
        end
        return t;
    endfunction

    initial begin
        forever begin
            @(posedge clock);
            cyc = cyc + 1;
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            case (rdy_mode)
                1:       out_ready = ~out_ready;
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: payload stability under stall, beat scoreboard, result on done.
    initial begin
        beat_t   cur;
        beat_t   prev;
        beat_t   exp_b;
        result_t exp_r;
        logic    stalled;
        stalled = 1'b0;
        prev    = '0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                stalled = 1'b0;
                continue;
            end
            cur = {out_digit, out_cand, out_pos, out_last};
            if (stalled) begin
                check("stall_valid_held", 64'(out_valid), 64'd1);
                check("stall_payload", 64'(cur), 64'(prev));
            end
            if (out_valid && out_ready) begin
                xfer_cnt++;
                check("beat_expected", 64'(beat_q.size() > 0), 64'd1);
                if (beat_q.size() > 0) begin
                    exp_b = beat_q.pop_front();
                    check("beat{digit,cand,pos,last}", 64'(cur), 64'(exp_b));
                end
            end
            stalled = out_valid && !out_ready;
            prev    = cur;
            if (done) begin
                done_cnt++;
                check("done_expected", 64'(res_q.size() > 0), 64'd1);
                if (res_q.size() > 0) begin
                    exp_r = res_q.pop_front();
                    check("result{winner,tie,bcd_err}", 64'({winner, tie, bcd_err}), 64'(exp_r));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [TW-1:0] t_basic;
        logic [TW-1:0] t_tmp;
        int            f_rel;
        int            d_rel;
        int            base;
        int            dc;

        reset = 1'b0;
        start = 1'b0;
        tally = '0;

        // Reset held: start must be ignored, everything stays zero.
        repeat (2) @(negedge clock);
        check("reset_outputs", 64'(all_outs), 64'd0);
        @(posedge clock);
        #1;
        tally = rand_tally();
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("reset_start_ignored", 64'(all_outs), 64'd0);
        end
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("idle_after_release", 64'(all_outs), 64'd0);

        // Basic read at full throughput.
        t_basic = pack_dec(3, 0, 1, 0, 2);
        rdy_mode = 0;
        issue_start(t_basic);
        wait_done(f_rel, d_rel);
        check("first_beat_cycle", 64'(f_rel), 64'd5);
        check("done_cycle", 64'(d_rel), 64'd35);

        // Alternating backpressure.
        rdy_mode = 1;
        base = xfer_cnt;
        issue_start(t_basic);
        wait_done(f_rel, d_rel);
        check("bp_transfer_count", 64'(xfer_cnt - base), 64'd30);

        // Tie between Leandro and Mateus; the null tally is larger but excluded.
        rdy_mode = 2;
        issue_start(pack_dec(100, 120, 120, 7, 999999));
        wait_done(f_rel, d_rel);
        check("tie_winner", 64'(winner), 64'(LEANDRO));
        check("tie_flag", 64'(tie), 64'd1);

        // Tally change and start pulse during SEND leave the stream intact.
        rdy_mode = 0;
        issue_start(pack_dec(5, 9, 12, 12, 40));
        repeat (8) @(posedge clock);
        #1;
        tally = rand_tally();
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        wait_done(f_rel, d_rel);
        repeat (2) @(negedge clock);
        check("no_restart_after_done", 64'(busy), 64'd0);

        // Reset around beat 10 aborts without a done pulse.
        issue_start(pack_dec(1, 2, 3, 50, 0));
        base = xfer_cnt;
        for (int k = 0; k < 200; k++) begin
            @(posedge clock);
            #2;
            if (xfer_cnt - base >= 10) break;
        end
        check("pre_abort_winner", 64'(winner), 64'(PABLO));
        reset = 1'b0;
        #1;
        check("abort_valid", 64'(out_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_winner", 64'(winner), 64'd0);
        beat_q.delete();
        res_q.delete();
        dc = done_cnt;
        @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (60) @(negedge clock);
        check("no_done_after_abort", 64'(done_cnt - dc), 64'd0);

        // Invalid digit in Pablo's tally.
        t_tmp = pack_dec(10, 20, 30, 40, 50);
        t_tmp[(PABLO*ND+2)*4 +: 4] = 4'hA;
        rdy_mode = 2;
        issue_start(t_tmp);
        wait_done(f_rel, d_rel);
        check("bcd_err_set", 64'(bcd_err), 64'd1);
        issue_start(t_basic);
        @(negedge clock);
        check("bcd_err_cleared", 64'(bcd_err), 64'd0);
        wait_done(f_rel, d_rel);

        // Randomized reads.
        for (int n = 0; n < 12; n++) begin
            rdy_mode = $urandom_range(0, 2);
            issue_start(rand_tally());
            wait_done(f_rel, d_rel);
        end

        repeat (3) @(negedge clock);
        check("final_beat_queue", 64'(beat_q.size()), 64'd0);
        check("final_result_queue", 64'(res_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
